// File: rtl/conv_stream_source.sv
// Frame-store backed stream source: one kernel beat, then the whole image as AXI-Stream pixels.
// Optional stall counter output enabled by defining CONV_STREAM_SOURCE_PERF_EN.
module conv_stream_source #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_KERNEL   = 5,
  parameter int unsigned MAX_CHANNELS = 3,
  parameter int unsigned IMAGE_SIZE   = 64
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    wr_en,
  input  logic [$clog2(IMAGE_SIZE*IMAGE_SIZE)-1:0]                wr_addr,
  input  logic [MAX_CHANNELS*DATA_WIDTH-1:0]                      wr_data,
  input  logic                                                    start,
  input  logic [MAX_CHANNELS*MAX_KERNEL*MAX_KERNEL*DATA_WIDTH-1:0] kernel_data,
  input  logic [3:0]                                              kernel_size,
  input  logic [3:0]                                              num_channels,
  output logic                                                    busy,
  output logic                                                    done,
  output logic                                                    m_kernel_tvalid,
  input  logic                                                    m_kernel_tready,
  output logic [MAX_CHANNELS*MAX_KERNEL*MAX_KERNEL*DATA_WIDTH-1:0] m_kernel_tdata,
  output logic                                                    m_axis_tvalid,
  input  logic                                                    m_axis_tready,
  output logic [MAX_CHANNELS*DATA_WIDTH-1:0]                      m_axis_tdata,
  output logic                                                    m_axis_tlast
`ifdef CONV_STREAM_SOURCE_PERF_EN
  ,
  output logic [31:0]                                             stall_count
`endif
);

  localparam int unsigned NumPix = IMAGE_SIZE * IMAGE_SIZE;
  localparam int unsigned AddrW  = $clog2(NumPix);
  localparam int unsigned PixW   = MAX_CHANNELS * DATA_WIDTH;
  localparam int unsigned Taps   = MAX_KERNEL * MAX_KERNEL;
  localparam int unsigned KernW  = MAX_CHANNELS * Taps * DATA_WIDTH;
  localparam logic [15:0] LastIdx = 16'(NumPix - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSendKernel,
    StSendPixels,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic [PixW-1:0]  frame_mem [NumPix];
  logic [PixW-1:0]  mem_rd;
  logic [PixW-1:0]  pix_masked;
  logic [KernW-1:0] kernel_masked;

  logic [KernW-1:0] kernel_q;
  logic [3:0]       num_ch_q;
  logic [15:0]      pix_idx_q;
  logic             out_valid_q;
  logic [PixW-1:0]  out_data_q;
  logic             out_last_q;

  logic start_acc;
  logic kern_acc;
  logic beat_acc;
  logic load;

  // Frame store: no reset, so image contents survive an aborted transfer.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      frame_mem[wr_addr] <= wr_data;
    end
  end

  assign mem_rd = frame_mem[pix_idx_q[AddrW-1:0]];

  always_comb begin
    pix_masked = '0;
    for (int c = 0; c < int'(MAX_CHANNELS); c++) begin
      if (c < int'(num_ch_q)) begin
        pix_masked[c*DATA_WIDTH +: DATA_WIDTH] = mem_rd[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Taps are laid out channel-major: tap t of channel c sits at index c*Taps + t.
  always_comb begin
    kernel_masked = '0;
    for (int c = 0; c < int'(MAX_CHANNELS); c++) begin
      for (int t = 0; t < int'(Taps); t++) begin
        if ((c < int'(num_channels)) && (t < int'(kernel_size) * int'(kernel_size))) begin
          kernel_masked[(c*int'(Taps) + t)*DATA_WIDTH +: DATA_WIDTH] =
            kernel_data[(c*int'(Taps) + t)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign start_acc = (state_q == StIdle) && start;
  assign kern_acc  = (state_q == StSendKernel) && m_kernel_tready;
  assign beat_acc  = out_valid_q && m_axis_tready;
  // Refill the output register when it is empty or draining, until the last pixel is loaded.
  assign load      = (state_q == StSendPixels) && (!out_valid_q || m_axis_tready) &&
                     (pix_idx_q <= LastIdx);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       if (start) state_d = StSendKernel;
      StSendKernel: if (m_kernel_tready) state_d = StSendPixels;
      StSendPixels: if (beat_acc && out_last_q) state_d = StFinish;
      StFinish:     state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kernel_q    <= '0;
      num_ch_q    <= '0;
      pix_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        kernel_q <= kernel_masked;
        num_ch_q <= num_channels;
      end
      if (kern_acc) begin
        pix_idx_q   <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pix_masked;
        out_last_q  <= (pix_idx_q == LastIdx);
        pix_idx_q   <= pix_idx_q + 16'd1;
      end else if (beat_acc) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StFinish);
  assign m_kernel_tvalid = (state_q == StSendKernel);
  assign m_kernel_tdata  = kernel_q;
  assign m_axis_tvalid   = out_valid_q;
  assign m_axis_tdata    = out_data_q;
  assign m_axis_tlast    = out_last_q;

`ifdef CONV_STREAM_SOURCE_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (out_valid_q && !m_axis_tready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
